// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (read-only) and
//   load/store (read/write). One transaction in flight at a time, round-robin
//   on ties, and a watchdog that aborts a transaction the memory never finishes.
//
// Ports
//   clk_i, rst_i                  clock, synchronous active-high reset
//   if_req_i/if_addr_i            fetch request + address (held until if_gnt_o)
//   if_gnt_o/if_rvalid_o          fetch accept pulse / response pulse
//   ls_req_i/ls_we_i/ls_addr_i/
//   ls_wdata_i/ls_wmask_i         load/store request + payload (held until ls_gnt_o)
//   ls_gnt_o/ls_rvalid_o          load/store accept pulse / response-or-ack pulse
//   rdata_o                       response data, qualified by *_rvalid_o
//   err_o                         pulses with the owner's rvalid on watchdog abort
//   busy_o                        a transaction is being issued or awaited
//   mem_req_o/mem_we_o/mem_addr_o/
//   mem_wdata_o/mem_wmask_o       memory request, payload muxed from the owner
//   mem_gnt_i                     memory accepted the request
//   mem_rvalid_i/mem_rdata_i      memory response
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  input  logic                ls_req_i,
  input  logic                ls_we_i,
  input  logic [ADDR_W-1:0]   ls_addr_i,
  input  logic [DATA_W-1:0]   ls_wdata_i,
  input  logic [DATA_W/8-1:0] ls_wmask_i,
  output logic                ls_gnt_o,
  output logic                ls_rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                err_o,
  output logic                busy_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  // Counter only has to reach TIMEOUT (one past the abort point).
  localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;   // 1 = load/store, 0 = fetch
  logic              last_q,  last_d;    // last granted, same encoding
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;

  logic own_req, wd_hit, gnt, rv;

  assign own_req = owner_q ? ls_req_i : if_req_i;
  // >= rather than == so a grant landing exactly on the limit cycle still
  // gets aborted on the following WAIT cycle instead of slipping past.
  assign wd_hit  = (TIMEOUT != 0) && (wd_cnt_q >= WD_LIM);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    wd_cnt_d    = wd_cnt_q;
    gnt         = 1'b0;
    rv          = 1'b0;
    err_o       = 1'b0;
    rdata_o     = '0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    busy_o      = (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (if_req_i || ls_req_i) begin
          state_d  = S_REQ;
          wd_cnt_d = '0;
          // On a tie, favour whoever was not granted last.
          owner_d  = (if_req_i && ls_req_i) ? ~last_q : ls_req_i;
        end
      end
      S_REQ: begin
        mem_req_o   = 1'b1;
        mem_we_o    = owner_q & ls_we_i;
        mem_addr_o  = owner_q ? ls_addr_i : if_addr_i;
        mem_wdata_o = owner_q ? ls_wdata_i : '0;
        mem_wmask_o = owner_q ? ls_wmask_i : '0;
        wd_cnt_d    = wd_cnt_q + WD_W'(1);
        if (!own_req) begin
          state_d = S_IDLE;             // withdrawn before acceptance: silent
        end else if (mem_gnt_i) begin
          gnt     = 1'b1;               // mem_rvalid_i is ignored here
          last_d  = owner_q;
          state_d = S_WAIT;
        end else if (wd_hit) begin
          rv      = 1'b1;
          err_o   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        wd_cnt_d = wd_cnt_q + WD_W'(1);
        rdata_o  = mem_rdata_i;
        if (mem_rvalid_i) begin
          rv      = 1'b1;
          state_d = S_IDLE;
        end else if (wd_hit) begin
          rv      = 1'b1;
          err_o   = 1'b1;
          rdata_o = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if_gnt_o    = gnt & ~owner_q;
    ls_gnt_o    = gnt &  owner_q;
    if_rvalid_o = rv  & ~owner_q;
    ls_rvalid_o = rv  &  owner_q;

    // Reset aborts silently, including the cycle it is asserted in.
    if (rst_i) begin
      if_gnt_o    = 1'b0;
      ls_gnt_o    = 1'b0;
      if_rvalid_o = 1'b0;
      ls_rvalid_o = 1'b0;
      err_o       = 1'b0;
      rdata_o     = '0;
      busy_o      = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_wmask_o = '0;
    end
  end

endmodule
